// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: direct-mapped I-cache lookup, miss stall and word-serial line refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINES = 64,
    parameter int LINE_WORDS = 4,
    localparam int OFF = $clog2(LINE_WORDS * 4),
    localparam int IDX = $clog2(LINES),
    localparam int TAG = ADDR_W - IDX - OFF,
    localparam int RA = $clog2(LINES * LINE_WORDS / 2),
    localparam int WB = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_req,
    input  logic              redirect,
    input  logic              flush,
    output logic              fetch_stall,
    output logic [RA-1:0]     ram_raddr,
    output logic              ram_we,
    output logic [RA-1:0]     ram_waddr,
    output logic [63:0]       ram_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);
    typedef enum logic [1:0] {RUN, REQ, RSP, REPLAY} state_t;
    state_t state;
    logic [LINES-1:0] valid;
    logic [TAG-1:0] tags [LINES];
    logic [ADDR_W-1:3] lk_addr, miss_addr;
    logic lk_valid, redirect_pend, flush_pend;
    logic [WB-1:0] w;
    logic [31:0] buffer;
    logic [IDX-1:0] lk_idx, miss_idx;
    logic miss, start, last, unused;

    assign unused = ^fetch_addr[2:0];
    assign lk_idx = lk_addr[OFF+IDX-1:OFF];
    assign miss_idx = miss_addr[OFF+IDX-1:OFF];
    assign miss = lk_valid && !(valid[lk_idx] && tags[lk_idx] == lk_addr[ADDR_W-1:OFF+IDX]);
    // flush and redirect both veto a refill start in the same cycle
    assign start = state == RUN && miss && !redirect && !flush;
    assign last = state == RSP && mem_rsp_valid && w == WB'(LINE_WORDS - 1);
    assign fetch_stall = state != RUN || start;
    assign ram_raddr = state == RUN ? fetch_addr[OFF+IDX-1:3] : miss_addr[OFF+IDX-1:3];
    assign ram_we = state == RSP && mem_rsp_valid && w[0];
    assign ram_waddr = RA'({miss_idx, w} >> 1);
    assign ram_wdata = ram_we ? {mem_rsp_data, buffer} : '0;
    assign mem_req_valid = state == REQ;
    assign mem_req_addr = mem_req_valid ? {miss_addr[ADDR_W-1:OFF], w, 2'b00} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            valid <= '0;
            lk_addr <= '0;
            lk_valid <= 1'b0;
            miss_addr <= '0;
            w <= '0;
            buffer <= '0;
            redirect_pend <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (start) begin
                        miss_addr <= lk_addr;
                        w <= '0;
                        redirect_pend <= 1'b0;
                        flush_pend <= 1'b0;
                        state <= REQ;
                    end else begin
                        lk_addr <= fetch_addr[ADDR_W-1:3];
                        lk_valid <= fetch_req && !redirect && !flush;
                    end
                end
                REQ: if (mem_req_ready) state <= RSP;
                RSP: if (mem_rsp_valid) begin
                    if (!w[0]) buffer <= mem_rsp_data;
                    w <= w + 1'b1;
                    if (last) lk_valid <= 1'b0;
                    state <= !last ? REQ : (redirect_pend || redirect) ? RUN : REPLAY;
                end
                REPLAY: begin
                    lk_addr <= miss_addr;
                    lk_valid <= !(redirect_pend || redirect);
                    state <= RUN;
                end
            endcase
            if (state != RUN) begin
                if (redirect) redirect_pend <= 1'b1;
                if (flush) flush_pend <= 1'b1;
            end
            // a flush seen during the refill also wipes the line just written
            if ((flush && state inside {RUN, REPLAY}) || (last && (flush_pend || flush))) valid <= '0;
            else if (last) valid[miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (last) tags[miss_idx] <= miss_addr[ADDR_W-1:OFF+IDX];

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits <= '0;
            perf_misses <= '0;
        end else begin
            if (state == RUN && lk_valid && !miss && perf_hits != '1) perf_hits <= perf_hits + 1'b1;
            if (start && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed bench with memory model and request/write scoreboards.
module tb_icache_refill_ctrl;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] fetch_addr = '0, mem_rsp_data = '0, mem_req_addr;
    logic fetch_req = 1'b0, redirect = 1'b0, flush = 1'b0, mem_req_ready = 1'b1, mem_rsp_valid = 1'b0;
    logic fetch_stall, ram_we, mem_req_valid;
    logic [6:0] ram_raddr, ram_waddr;
    logic [63:0] ram_wdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_refill_ctrl dut (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
        .redirect(redirect), .flush(flush), .fetch_stall(fetch_stall), .ram_raddr(ram_raddr),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ICACHE_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [31:0] exp_addr_q[$];
    logic [6:0] exp_wa_q[$];
    logic [63:0] exp_wd_q[$];
    logic obs_stall, obs_memv, obs_we, pend = 1'b0, last_memv;
    logic [6:0] obs_raddr, last_raddr;
    logic [31:0] obs_maddr, pend_addr;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h1234;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, then answer an accepted request on the following cycle.
    task automatic step();
        #2;
        obs_stall = fetch_stall;
        obs_raddr = ram_raddr;
        obs_memv = mem_req_valid;
        obs_maddr = mem_req_addr;
        obs_we = ram_we;
        if (ram_we) begin
            if (exp_wa_q.size() == 0) chk("ram_we_unexpected", ram_we, 0);
            else begin
                chk("ram_waddr", ram_waddr, exp_wa_q.pop_front());
                chk("ram_wdata", ram_wdata, exp_wd_q.pop_front());
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (exp_addr_q.size() == 0) chk("mem_req_unexpected", mem_req_valid, 0);
            else chk("mem_req_addr", mem_req_addr, exp_addr_q.pop_front());
            pend = 1'b1;
            pend_addr = mem_req_addr;
        end
        @(negedge clk);
        mem_rsp_valid = pend;
        mem_rsp_data = pend ? mdata(pend_addr) : '0;
        pend = 1'b0;
    endtask

    task automatic exp_line(logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
        for (int p = 0; p < 2; p++) begin
            exp_wa_q.push_back(7'(base >> 3) + 7'(p));
            exp_wd_q.push_back({mdata(base + 32'(8 * p + 4)), mdata(base + 32'(8 * p))});
        end
    endtask

    task automatic present(logic [31:0] a);
        fetch_addr = a;
        fetch_req = 1'b1;
        step();
        chk("present_no_stall", obs_stall, 0);
        fetch_req = 1'b0;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        step();
        while (obs_stall && n < 100) begin
            n++;
            last_raddr = obs_raddr;
            last_memv = obs_memv;
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] p0;
        fetch_addr = 32'h18;
        step();
        chk("rst_stall", obs_stall, 0);
        chk("rst_memv", obs_memv, 0);
        chk("rst_maddr", obs_maddr, 0);
        chk("rst_we", obs_we, 0);
        chk("rst_raddr", obs_raddr, 3);
        reset = 1'b1;
        step();
        // cold miss on line 0
        exp_line(32'h0);
        present(32'h0);
        count_stall(n);
        chk("t1_stall_cycles", n, 10);
        chk("t1_replay_raddr", last_raddr, 0);
        chk("t1_replay_memv", last_memv, 0);
        // hit in the freshly filled line
`ifdef ICACHE_PERF_EN
        p0 = perf_hits;
`endif
        present(32'h8);
        count_stall(n);
        chk("t2_hit_no_stall", n, 0);
`ifdef ICACHE_PERF_EN
        chk("t2_perf_hits", perf_hits, p0 + 1);
`endif
        // conflicting tag evicts line 0
        exp_line(32'h400);
        present(32'h400);
        count_stall(n);
        chk("t3_conflict_stall", n, 10);
        exp_line(32'h0);
        present(32'h0);
        count_stall(n);
        chk("t3_evicted_stall", n, 10);
        // memory back-pressure
        exp_line(32'h80);
        mem_req_ready = 1'b0;
        present(32'h80);
        step();
        chk("t4_miss_stall", obs_stall, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", obs_memv, 1);
            chk("t4_hold_addr", obs_maddr, 32'h80);
            chk("t4_hold_stall", obs_stall, 1);
        end
        mem_req_ready = 1'b1;
        count_stall(n);
        chk("t4_rest_stall", n, 9);
        // redirect during the second word's response
        exp_line(32'h40);
        present(32'h40);
        repeat (4) step();
        redirect = 1'b1;
        step();
        chk("t5_redirect_stall", obs_stall, 1);
        redirect = 1'b0;
        count_stall(n);
        chk("t5_no_replay", n, 4);
        present(32'h40);
        count_stall(n);
        chk("t5_line_valid", n, 0);
        // redirect on a RUN miss starts nothing
        fetch_addr = 32'h100;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        redirect = 1'b1;
        step();
        chk("rd_run_stall", obs_stall, 0);
        redirect = 1'b0;
        count_stall(n);
        chk("rd_run_no_refill", n, 0);
        // flush during refill: replay misses and refills again
`ifdef ICACHE_PERF_EN
        p0 = perf_misses;
`endif
        exp_line(32'h20);
        exp_line(32'h20);
        present(32'h20);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        count_stall(n);
        chk("t6_double_refill", n, 18);
`ifdef ICACHE_PERF_EN
        chk("t6_perf_misses", perf_misses, p0 + 2);
`endif
        present(32'h20);
        count_stall(n);
        chk("t6_refilled_hit", n, 0);
        exp_line(32'h0);
        present(32'h8);
        count_stall(n);
        chk("t6_line0_flushed", n, 10);
        // flush coinciding with a miss wins
        present(32'h30);
        flush = 1'b1;
        step();
        chk("fm_stall", obs_stall, 0);
        flush = 1'b0;
        count_stall(n);
        chk("fm_no_refill", n, 0);
        exp_line(32'h20);
        present(32'h20);
        count_stall(n);
        chk("fm_flushed_line", n, 10);
        chk("sb_addr_drained", exp_addr_q.size(), 0);
        chk("sb_write_drained", exp_wa_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped I-cache controller in front of the dual-issue instruction fetcher.
- Owns the tag/valid store and the read address of the 64-bit instruction data RAM. It looks up each fetch, stalls the fetcher on a miss, and refills the missed line from a 32-bit memory port one word at a time.
- After a refill it replays the missed address so the fetcher receives the data with the RAM's normal 1-cycle latency.

Parameters:
- ADDR_W, 32: address width.
- LINES, 64: number of cache lines; power of 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_addr  in  ADDR_W  fetcher PC, 8-byte aligned.
- fetch_req  in  1  fetch_addr is a real request this cycle.
- redirect  in  1  branch redirect from the branch unit; the pending lookup/replay is discarded.
- flush  in  1  invalidate all lines (fence.i).
- fetch_stall  out  1  to the fetcher's stall input.
- ram_raddr  out  RA  data RAM read index, RA = log2(LINES*LINE_WORDS/2).
- ram_we  out  1  data RAM write strobe.
- ram_waddr  out  RA  data RAM write index.
- ram_wdata  out  64  {odd word, even word}.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  word address of the request.
- mem_rsp_valid  in  1  read data returned (in order, one per request).
- mem_rsp_data  in  32  read data.

Behaviour:
Address fields:
- OFF = log2(LINE_WORDS*4), IDX = log2(LINES), TAG = ADDR_W-IDX-OFF.
- idx = addr[OFF+IDX-1:OFF]; ram index = addr[OFF+IDX-1:3].

Reset:
- All valid bits 0, state RUN, lk_valid 0.
- All outputs 0; ram_raddr follows fetch_addr.

States: RUN, REQ, RSP, REPLAY.

RUN:
- ram_raddr = fetch_addr[OFF+IDX-1:3].
- Lookup register (lk_addr, lk_valid) captures fetch_addr/fetch_req every cycle in which fetch_stall=0.
- miss = lk_valid && !(valid[idx] && tag==lk_tag). Compare is on the registered address, i.e. 1 cycle after presentation.
- fetch_stall = miss && !redirect, combinational.
- If redirect: lk_valid<=0 and no refill starts.
- If miss && !redirect: latch miss_addr=lk_addr, set word count w=0, go to REQ.

REQ:
- mem_req_valid=1, mem_req_addr = {miss line base} + 4*w.
- Address and valid stay stable until mem_req_ready; then go to RSP.

RSP:
- Wait for mem_rsp_valid.
- Even w: hold the word in a buffer.
- Odd w: ram_we=1 for one cycle, ram_waddr = line index*(LINE_WORDS/2) + w/2, ram_wdata = {rsp, buffer}.
- If w < LINE_WORDS-1: w++ and go to REQ.
- On the last word: set valid[idx]=1 and tag[idx]=miss tag; then go to REPLAY, or to RUN if redirect_pend.

REPLAY:
- ram_raddr = miss_addr index, fetch_stall=1 for exactly 1 cycle.
- Then RUN with lk_addr=miss_addr, lk_valid=1 (hit next cycle).

fetch_stall:
- Held at 1 for the whole of REQ/RSP/REPLAY.

redirect outside RUN:
- Sets redirect_pend. The refill still completes because memory is not cancellable.
- Replay is skipped; RUN resumes with lk_valid=0.

flush:
- In RUN: all valid bits cleared next edge; lk_valid<=0.
- In REQ/RSP/REPLAY: sets flush_pend. At refill end all valid bits are cleared, including the new line, and then REPLAY proceeds, so the replay misses again.

Simultaneous flush+miss in RUN:
- Flush wins; no refill starts; stall=0.

Async reset mid-refill:
- Abandons the refill immediately; the outstanding memory response is ignored by the memory side's own reset.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined: adds outputs perf_hits[31:0] and perf_misses[31:0], both saturating at 0xFFFFFFFF and cleared by reset.
  - perf_hits increments on each RUN cycle with lk_valid && !miss.
  - perf_misses increments on each refill start.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults, reset then fetch_req with fetch_addr=0x0, memory ready always, 1-cycle response:
   - fetch_stall rises 1 cycle after presentation.
   - Requests go to 0x0, 0x4, 0x8, 0xC.
   - ram_we pulses with waddr 0 then 1.
   - One REPLAY cycle with ram_raddr=0, then stall=0.
2. After test 1, fetch 0x8: hit, fetch_stall stays 0, no mem_req_valid.
3. Fetch 0x400 (same idx 0, different tag):
   - Miss; refill of 0x400..0x40C.
   - Then fetch 0x0 misses again (eviction).
4. On a miss, mem_req_ready held low 5 cycles: mem_req_valid=1 and mem_req_addr constant the whole time; stall held.
5. redirect pulsed during RSP of word 1:
   - All 4 words are still fetched and the line becomes valid.
   - No REPLAY cycle; lk_valid=0 on return to RUN.
6. flush pulsed during refill of 0x20:
   - After completion all lines are invalid.
   - Replay of 0x20 misses and triggers a second refill.
   - With ICACHE_PERF_EN, perf_misses=2.
